// File: rtl/imm_decode_stage_pkg.sv
// Shared opcode/funct3 constants and immediate-format encoding for the
// immediate decode stage.
package imm_decode_stage_pkg;

  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_FENCE     = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;

  typedef enum logic [2:0] {
    FMT_NONE  = 3'd0,
    FMT_I     = 3'd1,
    FMT_SHAMT = 3'd2,
    FMT_S     = 3'd3,
    FMT_B     = 3'd4,
    FMT_U     = 3'd5,
    FMT_J     = 3'd6,
    FMT_CSR   = 3'd7
  } imm_fmt_e;

endpackage

// File: rtl/imm_decode_stage_decode.sv
// Combinational immediate extractor: format, extended immediate and
// illegal-opcode flag from a 32-bit instruction word.
module imm_decode
  import imm_decode_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     inst,
  output logic [XLEN-1:0] imm,
  output imm_fmt_e        fmt,
  output logic            illegal
);

  localparam int SHAMT_W = (XLEN == 64) ? 6 : 5;
  localparam logic [5:0] SHAMT_MASK = 6'((1 << SHAMT_W) - 1);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [31:0] raw;
  logic        sext;
  logic        word_op;

  assign opcode = inst[6:0];
  assign funct3 = inst[14:12];

  always_comb begin
    fmt     = FMT_NONE;
    illegal = 1'b0;
    raw     = '0;
    sext    = 1'b1;
    word_op = (opcode == OPC_OP_IMM_32);
    case (opcode)
      OPC_LUI, OPC_AUIPC: begin
        fmt = FMT_U;
        raw = {inst[31:12], 12'b0};
      end
      OPC_JAL: begin
        fmt = FMT_J;
        raw = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      end
      OPC_BRANCH: begin
        fmt = FMT_B;
        raw = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      end
      OPC_STORE: begin
        fmt = FMT_S;
        raw = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      end
      OPC_LOAD, OPC_JALR: begin
        fmt = FMT_I;
        raw = {{20{inst[31]}}, inst[31:20]};
      end
      OPC_OP_IMM, OPC_OP_IMM_32: begin
        // OP-IMM-32 exists only on RV64; its shifts carry a 5-bit shamt.
        if (word_op && XLEN != 64) begin
          illegal = 1'b1;
        end else if (funct3 == F3_SLL || funct3 == F3_SRL_SRA) begin
          fmt  = FMT_SHAMT;
          sext = 1'b0;
          raw  = {26'b0, inst[25:20] & (word_op ? 6'h1F : SHAMT_MASK)};
        end else begin
          fmt = FMT_I;
          raw = {{20{inst[31]}}, inst[31:20]};
        end
      end
      OPC_SYSTEM: begin
        fmt  = FMT_CSR;
        sext = 1'b0;
        raw  = {27'b0, inst[19:15]};
      end
      OPC_OP, OPC_FENCE: ;
      default: illegal = 1'b1;
    endcase
    imm = sext ? XLEN'($signed(raw)) : XLEN'(raw);
  end

endmodule

// File: rtl/imm_decode_stage.sv
// Immediate decode stage: combinational decode feeding a 2-entry skid FIFO
// with valid/ready handshakes on both sides.
module imm_decode_stage
  import imm_decode_stage_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag
);

  logic [XLEN-1:0]  dec_imm;
  imm_fmt_e         dec_fmt;
  logic             dec_illegal;

  logic [XLEN-1:0]  imm_q [2];
  imm_fmt_e         fmt_q [2];
  logic             ill_q [2];
  logic [TAG_W-1:0] tag_q [2];

  logic [1:0] count;
  logic       wr_ptr;
  logic       rd_ptr;
  logic       ready_en;
  logic       push;
  logic       pop;

  imm_decode #(.XLEN(XLEN)) u_decode (
    .inst    (in_inst),
    .imm     (dec_imm),
    .fmt     (dec_fmt),
    .illegal (dec_illegal)
  );

  // ready_en holds in_ready low through reset and releases it one edge later.
  assign in_ready  = ready_en && (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;

  assign out_imm     = imm_q[rd_ptr];
  assign out_fmt     = fmt_q[rd_ptr];
  assign out_illegal = ill_q[rd_ptr];
  assign out_tag     = tag_q[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count    <= '0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      ready_en <= 1'b0;
      for (int unsigned i = 0; i < 2; i++) begin
        imm_q[i] <= '0;
        fmt_q[i] <= FMT_NONE;
        ill_q[i] <= 1'b0;
        tag_q[i] <= '0;
      end
    end else begin
      ready_en <= 1'b1;
      if (flush) begin
        count  <= '0;
        wr_ptr <= 1'b0;
        rd_ptr <= 1'b0;
      end else begin
        if (push) begin
          imm_q[wr_ptr] <= dec_imm;
          fmt_q[wr_ptr] <= dec_fmt;
          ill_q[wr_ptr] <= dec_illegal;
          tag_q[wr_ptr] <= in_tag;
          wr_ptr        <= ~wr_ptr;
        end
        if (pop) rd_ptr <= ~rd_ptr;
        count <= count + 2'(push) - 2'(pop);
      end
    end
  end

endmodule

// File: tb/tb_imm_decode_stage.sv
// Directed bench for imm_decode_stage: XLEN=32 and XLEN=64 instances with
// hand-computed expected immediates, handshake and flush/reset checks.
module tb_imm_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_inst = '0;
  logic [31:0] in_tag = '0;

  logic        in_valid32 = 1'b0;
  logic        in_ready32, out_valid32, out_illegal32;
  logic [31:0] out_imm32, out_tag32;
  logic [2:0]  out_fmt32;

  logic        in_valid64 = 1'b0;
  logic        in_ready64, out_valid64, out_illegal64;
  logic [63:0] out_imm64;
  logic [15:0] out_tag64;
  logic [2:0]  out_fmt64;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  always #5 clk = ~clk;

  imm_decode_stage #(.XLEN(32), .TAG_W(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid32), .in_ready(in_ready32), .in_inst(in_inst), .in_tag(in_tag),
    .out_valid(out_valid32), .out_ready(out_ready), .out_imm(out_imm32),
    .out_fmt(out_fmt32), .out_illegal(out_illegal32), .out_tag(out_tag32)
  );

  imm_decode_stage #(.XLEN(64), .TAG_W(16)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid64), .in_ready(in_ready64), .in_inst(in_inst), .in_tag(in_tag[15:0]),
    .out_valid(out_valid64), .out_ready(out_ready), .out_imm(out_imm64),
    .out_fmt(out_fmt64), .out_illegal(out_illegal64), .out_tag(out_tag64)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // One instruction through the XLEN=32 instance with out_ready held high.
  task automatic xfer32(input string name, input logic [31:0] inst, input logic [31:0] tag,
                        input logic [31:0] exp_imm, input logic [2:0] exp_fmt, input logic exp_ill);
    @(negedge clk);
    in_valid32 = 1'b1; in_inst = inst; in_tag = tag;
    @(negedge clk);
    in_valid32 = 1'b0;
    check({name, ".valid"}, 64'(out_valid32), 64'd1);
    check({name, ".imm"},   64'(out_imm32), 64'(exp_imm));
    check({name, ".fmt"},   64'(out_fmt32), 64'(exp_fmt));
    check({name, ".ill"},   64'(out_illegal32), 64'(exp_ill));
    check({name, ".tag"},   64'(out_tag32), 64'(tag));
  endtask

  task automatic xfer64(input string name, input logic [31:0] inst,
                        input logic [63:0] exp_imm, input logic [2:0] exp_fmt, input logic exp_ill);
    @(negedge clk);
    in_valid64 = 1'b1; in_inst = inst; in_tag = 32'h0000_ABCD;
    @(negedge clk);
    in_valid64 = 1'b0;
    check({name, ".valid"}, 64'(out_valid64), 64'd1);
    check({name, ".imm"},   out_imm64, exp_imm);
    check({name, ".fmt"},   64'(out_fmt64), 64'(exp_fmt));
    check({name, ".ill"},   64'(out_illegal64), 64'(exp_ill));
    check({name, ".tag"},   64'(out_tag64), 64'h0000_ABCD);
  endtask

  initial begin
    // Reset state
    #7;
    check("rst.valid", 64'(out_valid32), 64'd0);
    check("rst.ready", 64'(in_ready32), 64'd0);
    check("rst.imm",   64'(out_imm32), 64'd0);
    check("rst.fmt",   64'(out_fmt32), 64'd0);
    check("rst.tag",   64'(out_tag32), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("rst.ready_before_edge", 64'(in_ready32), 64'd0);
    @(negedge clk);
    check("rst.ready_after_edge", 64'(in_ready32), 64'd1);
    check("rst.ready64", 64'(in_ready64), 64'd1);

    // Formats, XLEN=32
    out_ready = 1'b1;
    xfer32("lui",   32'h800000B7, 32'd100, 32'h80000000, 3'd5, 1'b0);
    xfer32("srai",  32'h41F05093, 32'd101, 32'h0000001F, 3'd2, 1'b0);
    xfer32("lw",    32'hFFF0A083, 32'd102, 32'hFFFFFFFF, 3'd1, 1'b0);
    xfer32("lh",    32'h80009083, 32'd103, 32'hFFFFF800, 3'd1, 1'b0);
    xfer32("beq",   32'hFE000EE3, 32'd104, 32'hFFFFFFFC, 3'd4, 1'b0);
    xfer32("sw",    32'hFE112E23, 32'd105, 32'hFFFFFFFC, 3'd3, 1'b0);
    xfer32("jal",   32'h008000EF, 32'd106, 32'h00000008, 3'd6, 1'b0);
    xfer32("auipc", 32'h12345017, 32'd107, 32'h12345000, 3'd5, 1'b0);
    xfer32("csr",   32'h000FD073, 32'd108, 32'h0000001F, 3'd7, 1'b0);
    xfer32("add",   32'h003100B3, 32'd109, 32'h00000000, 3'd0, 1'b0);
    xfer32("fence", 32'h0FF0000F, 32'd110, 32'h00000000, 3'd0, 1'b0);
    xfer32("op7f",  32'hFFFFFFFF, 32'd111, 32'h00000000, 3'd0, 1'b1);
    xfer32("w32",   32'h0200101B, 32'd112, 32'h00000000, 3'd0, 1'b1);

    // Formats, XLEN=64
    xfer64("slli63", 32'h03F01013, 64'd63, 3'd2, 1'b0);
    xfer64("slliw",  32'h0200101B, 64'd0, 3'd2, 1'b0);
    xfer64("lui64",  32'h800000B7, 64'hFFFFFFFF_80000000, 3'd5, 1'b0);
    xfer64("addiw",  32'hFFF0809B, 64'hFFFFFFFF_FFFFFFFF, 3'd1, 1'b0);
    @(negedge clk);
    check("x64.drained", 64'(out_valid64), 64'd0);

    // Back-pressure: three offered, two accepted, order preserved
    out_ready = 1'b0;
    in_valid32 = 1'b1; in_inst = 32'h800000B7; in_tag = 32'd1;
    @(negedge clk);
    check("bp.ready_occ1", 64'(in_ready32), 64'd1);
    in_inst = 32'h41F05093; in_tag = 32'd2;
    @(negedge clk);
    check("bp.ready_full", 64'(in_ready32), 64'd0);
    check("bp.head_tag",   64'(out_tag32), 64'd1);
    in_inst = 32'hFFF0A083; in_tag = 32'd3;
    @(negedge clk);
    check("bp.still_full",  64'(in_ready32), 64'd0);
    check("bp.stable_tag",  64'(out_tag32), 64'd1);
    check("bp.stable_imm",  64'(out_imm32), 64'h80000000);
    out_ready = 1'b1;
    @(negedge clk);
    check("bp.second_tag", 64'(out_tag32), 64'd2);
    check("bp.second_imm", 64'(out_imm32), 64'h1F);
    check("bp.ready_occ1b", 64'(in_ready32), 64'd1);
    @(negedge clk);
    in_valid32 = 1'b0;
    check("bp.third_tag", 64'(out_tag32), 64'd3);
    check("bp.third_imm", 64'(out_imm32), 64'hFFFFFFFF);
    check("bp.third_valid", 64'(out_valid32), 64'd1);
    @(negedge clk);
    check("bp.empty", 64'(out_valid32), 64'd0);

    // Simultaneous push and pop at occupancy 1
    in_valid32 = 1'b1; in_inst = 32'h12345017; in_tag = 32'd7;
    @(negedge clk);
    check("pp.first", 64'(out_tag32), 64'd7);
    in_inst = 32'h008000EF; in_tag = 32'd8;
    @(negedge clk);
    in_valid32 = 1'b0;
    check("pp.new_tag", 64'(out_tag32), 64'd8);
    check("pp.new_imm", 64'(out_imm32), 64'd8);
    @(negedge clk);
    check("pp.empty", 64'(out_valid32), 64'd0);

    // Flush at occupancy 2 with in_valid high
    out_ready = 1'b0;
    in_valid32 = 1'b1; in_inst = 32'h800000B7; in_tag = 32'd20;
    @(negedge clk);
    in_tag = 32'd21;
    @(negedge clk);
    check("fl.full", 64'(in_ready32), 64'd0);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; in_valid32 = 1'b0;
    check("fl.valid", 64'(out_valid32), 64'd0);
    check("fl.ready", 64'(in_ready32), 64'd1);

    // Flush at occupancy 1 drops the same-cycle push
    in_valid32 = 1'b1; in_tag = 32'd22;
    @(negedge clk);
    flush = 1'b1; in_tag = 32'd23;
    @(negedge clk);
    flush = 1'b0; in_valid32 = 1'b0;
    check("fl1.valid", 64'(out_valid32), 64'd0);

    // Reset mid-burst
    in_valid32 = 1'b1; in_tag = 32'd30;
    @(negedge clk);
    in_tag = 32'd31;
    #2 rst_n = 1'b0;
    #1;
    check("mr.valid", 64'(out_valid32), 64'd0);
    check("mr.ready", 64'(in_ready32), 64'd0);
    check("mr.tag",   64'(out_tag32), 64'd0);
    in_valid32 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("mr.ready_back", 64'(in_ready32), 64'd1);
    check("mr.empty",      64'(out_valid32), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
